// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle between the FP datapath, the normalizer and the rounder.
// The master side is the upstream producer, which also drives out_ready.
interface fp_normalizer_if #(parameter int WIDTH = 48);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [WIDTH-1:0]  in_sig;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic signed [9:0] out_exp;
  logic [22:0]       out_mantissa;
  logic              out_guard;
  logic              out_round;
  logic              out_sticky;
  logic              out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mantissa,
           out_guard, out_round, out_sticky, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mantissa,
           out_guard, out_round, out_sticky, out_zero
  );
endinterface

// File: rtl/fp_normalizer.sv
// Iterative post-arithmetic normalizer: brings the hidden bit to WIDTH-2 with at most
// SHIFT_STEP left shifts per cycle, then splits the result into mantissa and GRS bits.
module fp_normalizer #(
  parameter int WIDTH      = 48,
  parameter int SHIFT_STEP = 8
) (
  input logic            clk,
  input logic            rst_n,
  fp_normalizer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_sig;
  logic signed [9:0] r_exp;
  logic              r_sign;
  logic              r_sticky;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_sign;
  logic signed [9:0] r_out_exp;
  logic [22:0]       r_out_mant;
  logic              r_out_guard;
  logic              r_out_round;
  logic              r_out_sticky;
  logic              r_out_zero;

  logic [WIDTH-1:0]  w_nxt_sig;
  logic signed [9:0] w_nxt_exp;
  logic              w_nxt_sticky;
  logic              w_done;
  logic              w_zero;
  logic              w_subn;
  logic              w_low_or;
  int                w_lz;
  int                w_shamt;

  // Distance from the highest set bit to the hidden-bit position, clamped by step and exponent.
  always_comb begin
    w_lz = 0;
    for (int i = 0; i <= WIDTH-2; i++)
      if (r_sig[i]) w_lz = WIDTH - 2 - i;
    w_shamt = w_lz;
    if (w_shamt > SHIFT_STEP) w_shamt = SHIFT_STEP;
    if (w_shamt > int'(r_exp) - 1) w_shamt = int'(r_exp) - 1;
  end

  always_comb begin
    w_nxt_sig    = r_sig;
    w_nxt_exp    = r_exp;
    w_nxt_sticky = r_sticky;
    w_done       = 1'b0;
    w_zero       = 1'b0;
    w_subn       = 1'b0;
    if (r_sig == '0) begin
      w_done = 1'b1;
      w_zero = 1'b1;
    end else if (r_sig[WIDTH-1]) begin
      w_nxt_sig    = r_sig >> 1;
      w_nxt_sticky = r_sticky | r_sig[0];
      w_nxt_exp    = r_exp + 10'sd1;
      w_done       = 1'b1;
    end else if (r_sig[WIDTH-2]) begin
      w_done = 1'b1;
    end else if (r_exp <= 10'sd1) begin
      w_done = 1'b1;
      w_subn = 1'b1;
    end else begin
      w_nxt_sig = r_sig << w_shamt;
      w_nxt_exp = r_exp - 10'(w_shamt);
    end
  end

  generate
    if (WIDTH > 27) begin : g_low
      assign w_low_or = |w_nxt_sig[WIDTH-28:0];
    end else begin : g_nolow
      assign w_low_or = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sig        <= '0;
      r_exp        <= '0;
      r_sign       <= 1'b0;
      r_sticky     <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sign   <= 1'b0;
      r_out_exp    <= '0;
      r_out_mant   <= '0;
      r_out_guard  <= 1'b0;
      r_out_round  <= 1'b0;
      r_out_sticky <= 1'b0;
      r_out_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_sig      <= bus.in_sig;
            r_exp      <= bus.in_exp;
            r_sign     <= bus.in_sign;
            r_sticky   <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_SHIFT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_sig    <= w_nxt_sig;
          r_exp    <= w_nxt_exp;
          r_sticky <= w_nxt_sticky;
          if (w_done) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_sign   <= r_sign;
            r_out_exp    <= (w_zero || w_subn) ? 10'sd0 : w_nxt_exp;
            r_out_mant   <= w_nxt_sig[WIDTH-3 -: 23];
            r_out_guard  <= w_nxt_sig[WIDTH-26];
            r_out_round  <= w_nxt_sig[WIDTH-27];
            r_out_sticky <= w_low_or | w_nxt_sticky;
            r_out_zero   <= w_zero;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_sign     = r_out_sign;
  assign bus.out_exp      = r_out_exp;
  assign bus.out_mantissa = r_out_mant;
  assign bus.out_guard    = r_out_guard;
  assign bus.out_round    = r_out_round;
  assign bus.out_sticky   = r_out_sticky;
  assign bus.out_zero     = r_out_zero;
endmodule

// File: tb/tb_fp_normalizer.sv
// Directed vector bench for fp_normalizer (WIDTH=48, SHIFT_STEP=8) plus backpressure and
// mid-operation reset sequences.
module tb_fp_normalizer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fp_normalizer_if #(.WIDTH(48)) bif ();
  fp_normalizer #(.WIDTH(48), .SHIFT_STEP(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sig;
    logic [9:0]  exp;
    logic        sign;
    logic [9:0]  x_exp;
    logic [22:0] x_mant;
    logic [2:0]  x_grs;
    logic        x_zero;
    int          x_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bif.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_drive", 64'(bif.in_ready), 64'd1);
  endtask

  // Drives one operand, returns edges counted from the accepting edge until out_valid.
  task automatic issue(input logic [47:0] sig, input logic [9:0] exp, input logic sign,
                       output int lat);
    wait_ready();
    bif.in_sig   = sig;
    bif.in_exp   = exp;
    bif.in_sign  = sign;
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    lat = 1;
    while (bif.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input int idx, input int lat);
    vec_t v = vecs[idx];
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.x_lat));
    chk($sformatf("v%0d_valid", idx), 64'(bif.out_valid), 64'd1);
    chk($sformatf("v%0d_in_ready_low", idx), 64'(bif.in_ready), 64'd0);
    chk($sformatf("v%0d_exp", idx), 64'(10'(bif.out_exp)), 64'(v.x_exp));
    chk($sformatf("v%0d_mant", idx), 64'(bif.out_mantissa), 64'(v.x_mant));
    chk($sformatf("v%0d_grs", idx), 64'({bif.out_guard, bif.out_round, bif.out_sticky}),
        64'(v.x_grs));
    chk($sformatf("v%0d_zero", idx), 64'(bif.out_zero), 64'(v.x_zero));
    chk($sformatf("v%0d_sign", idx), 64'(bif.out_sign), 64'(v.sign));
  endtask

  initial begin
    int lat;
    logic [37:0] snap;
    //            sig                  exp     sg    x_exp   x_mant        grs   zero lat
    vecs[0] = '{48'h4000_0000_0000, 10'd127, 1'b1, 10'd127, 23'h000000, 3'b000, 1'b0, 2};
    vecs[1] = '{48'hC000_0000_0001, 10'd127, 1'b0, 10'd128, 23'h400000, 3'b001, 1'b0, 2};
    vecs[2] = '{48'h0000_0000_0001, 10'd127, 1'b0, 10'd81,  23'h000000, 3'b000, 1'b0, 8};
    vecs[3] = '{48'h0000_1000_0000, 10'd10,  1'b1, 10'd0,   23'h004000, 3'b000, 1'b0, 4};
    vecs[4] = '{48'h0000_0000_0000, 10'd50,  1'b0, 10'd0,   23'h000000, 3'b000, 1'b1, 2};
    vecs[5] = '{48'h4000_00E0_0001, 10'd100, 1'b0, 10'd100, 23'h000001, 3'b111, 1'b0, 2};
    vecs[6] = '{48'h0000_0100_0000, 10'd1,   1'b0, 10'd0,   23'h000002, 3'b000, 1'b0, 2};
    vecs[7] = '{48'h8000_0000_0000, 10'd200, 1'b1, 10'd201, 23'h000000, 3'b000, 1'b0, 2};
    vecs[8] = '{48'h2000_0000_0000, 10'd5,   1'b0, 10'd4,   23'h000000, 3'b000, 1'b0, 3};
    vecs[9] = '{48'h0040_0000_0000, 10'd127, 1'b0, 10'd119, 23'h000000, 3'b000, 1'b0, 3};

    rst_n        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_sign  = 1'b0;
    bif.in_exp   = '0;
    bif.in_sig   = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(bif.in_ready), 64'd0);
    chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(bif.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].sig, vecs[i].exp, vecs[i].sign, lat);
      check_result(i, lat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_valid", i), 64'(bif.out_valid), 64'd0);
      chk($sformatf("v%0d_idle_ready", i), 64'(bif.in_ready), 64'd1);
    end

    // Backpressure: result must hold for 5 cycles while out_ready is low.
    bif.out_ready = 1'b0;
    issue(vecs[1].sig, vecs[1].exp, vecs[1].sign, lat);
    check_result(1, lat);
    snap = {bif.out_sign, bif.out_exp, bif.out_mantissa, bif.out_guard, bif.out_round,
            bif.out_sticky, bif.out_zero};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_outputs", 64'({bif.out_sign, bif.out_exp, bif.out_mantissa, bif.out_guard,
          bif.out_round, bif.out_sticky, bif.out_zero}), 64'(snap));
      chk("bp_hold_valid", 64'(bif.out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(bif.in_ready), 64'd0);
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(bif.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bif.in_ready), 64'd1);

    // Reset in the middle of a deep shift: operand is dropped, outputs clear.
    wait_ready();
    bif.in_sig   = vecs[2].sig;
    bif.in_exp   = vecs[2].exp;
    bif.in_sign  = 1'b1;
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift_valid", 64'(bif.out_valid), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_outputs_zero", 64'({bif.in_ready, bif.out_valid, bif.out_sign, bif.out_exp,
        bif.out_mantissa, bif.out_guard, bif.out_round, bif.out_sticky, bif.out_zero}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 64'(bif.in_ready), 64'd1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("no_stale_result", 64'(bif.out_valid), 64'd0);
    end

    // Block still works after the aborted operand.
    issue(vecs[3].sig, vecs[3].exp, vecs[3].sign, lat);
    check_result(3, lat);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
